// File: rtl/jk_excitation_driver.sv
// Drives a bank of external JK flip-flops toward a requested Q state using
// minimal J/K excitation, then watches the fed-back Q for completion or timeout.
module jk_excitation_driver #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 4,
  parameter int RETRIES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             error
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TRY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(RETRIES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] tgt_reg, tgt_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [TRY_W-1:0] tries_reg, tries_next;
  logic [WIDTH-1:0] j_reg, j_next;
  logic [WIDTH-1:0] k_reg, k_next;
  logic             done_reg, done_next;
  logic             error_reg, error_next;

  logic [WIDTH-1:0] exc_j, exc_k;
  logic             matched;

  // Set a 0 bit with J, clear a 1 bit with K; correct bits get neither,
  // so J and K are never high together on the same bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_exc
      assign exc_j[gi] = ~q_fb[gi] &  tgt_reg[gi];
      assign exc_k[gi] =  q_fb[gi] & ~tgt_reg[gi];
    end
  endgenerate

  assign matched      = (q_fb == tgt_reg);
  assign target_ready = (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    cnt_next   = cnt_reg;
    tries_next = tries_reg;
    j_next     = '0;
    k_next     = '0;
    done_next  = 1'b0;
    error_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (target_valid) begin
          tgt_next   = target;
          tries_next = '0;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        j_next     = exc_j;
        k_next     = exc_k;
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (matched) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          if (tries_reg < TRY_LIMIT) begin
            tries_next = tries_reg + 1'b1;
            state_next = DRIVE;
          end else begin
            error_next = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      tgt_reg   <= '0;
      cnt_reg   <= '0;
      tries_reg <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tgt_reg   <= tgt_next;
      cnt_reg   <= cnt_next;
      tries_reg <= tries_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      done_reg  <= done_next;
      error_reg <= error_next;
    end
  end

  assign j     = j_reg;
  assign k     = k_reg;
  assign done  = done_reg;
  assign error = error_reg;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver: a JK bank model (ideal or stuck)
// closes the loop, and every expected value is hand-computed.
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] target;
  logic       target_valid;
  logic       target_ready;
  logic [3:0] q_fb;
  logic [3:0] j, k;
  logic       done, error;

  // Bank model: when use_bank=0 Q is forced (stuck/preset), otherwise a JK bank.
  logic       use_bank;
  logic [3:0] q_force;
  logic [3:0] bank_q;

  int checks = 0;
  int errors = 0;

  jk_excitation_driver #(.WIDTH(4), .TIMEOUT(4), .RETRIES(1)) dut (
    .clk(clk), .reset(reset), .target(target), .target_valid(target_valid),
    .target_ready(target_ready), .q_fb(q_fb), .j(j), .k(k),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    bank_q <= use_bank ? ((j & ~bank_q) | (~k & bank_q)) : q_force;

  assign q_fb = use_bank ? bank_q : q_force;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ej, input logic [3:0] ek,
                         input logic ed, input logic ee, input logic er);
    chk({tag, ".j"}, 32'(j), 32'(ej));
    chk({tag, ".k"}, 32'(k), 32'(ek));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".error"}, 32'(error), 32'(ee));
    chk({tag, ".ready"}, 32'(target_ready), 32'(er));
  endtask

  initial begin
    logic [3:0] seq [0:7];
    reset = 1'b1; target = '0; target_valid = 1'b0; use_bank = 1'b0; q_force = '0;
    #12;
    chk_out("reset", 4'h0, 4'h0, 0, 0, 1);
    step();
    reset = 1'b0;

    // 1: ideal bank 0000 -> 1010
    use_bank = 1'b1; target = 4'b1010; target_valid = 1'b1;
    step(); target_valid = 1'b0;                       // E0
    chk_out("t1.e0", 4'h0, 4'h0, 0, 0, 0);
    step(); chk_out("t1.e1", 4'b1010, 4'h0, 0, 0, 0);
    step(); chk_out("t1.e2", 4'h0, 4'h0, 0, 0, 0);
    step(); chk_out("t1.e3", 4'h0, 4'h0, 1, 0, 1);
    step(); chk_out("t1.e4", 4'h0, 4'h0, 0, 0, 1);
    $display("txn 1 target=1010 q=%b", q_fb);

    // 2: already matching
    use_bank = 1'b0; q_force = 4'b0110; step();
    target = 4'b0110; target_valid = 1'b1;
    step(); target_valid = 1'b0;
    step(); chk_out("t2.e1", 4'h0, 4'h0, 0, 0, 0);
    step(); chk_out("t2.e2", 4'h0, 4'h0, 1, 0, 1);
    step(); chk_out("t2.e3", 4'h0, 4'h0, 0, 0, 1);
    $display("txn 2 target=0110 q=%b", q_fb);

    // 3: mixed 1100 -> 0101
    q_force = 4'b1100; step();
    use_bank = 1'b1; target = 4'b0101; target_valid = 1'b1;
    step(); target_valid = 1'b0;
    step(); chk_out("t3.e1", 4'b0001, 4'b1000, 0, 0, 0);
    step(); chk_out("t3.e2", 4'h0, 4'h0, 0, 0, 0);
    chk("t3.bank", 32'(q_fb), 32'(4'b0101));
    step(); chk_out("t3.e3", 4'h0, 4'h0, 1, 0, 1);
    $display("txn 3 target=0101 q=%b", q_fb);

    // 4: stuck bank 0000, target 1111 -> retry then error
    use_bank = 1'b0; q_force = 4'b0000; step();
    target = 4'b1111; target_valid = 1'b1;
    step(); target_valid = 1'b0;                       // E0
    for (int e = 1; e <= 11; e++) begin
      step();
      chk_out($sformatf("t4.e%0d", e),
              (e == 1 || e == 6) ? 4'b1111 : 4'h0, 4'h0, 0,
              (e == 10), (e >= 10));
    end
    $display("txn 4 target=1111 stuck error seen");

    // 5: async reset mid-WAIT, then fresh accept
    target = 4'b1111; target_valid = 1'b1;
    step(); target_valid = 1'b0;
    step(); chk("t5.pulse", 32'(j), 32'(4'b1111));
    #2 reset = 1'b1;
    #1 chk_out("t5.rst", 4'h0, 4'h0, 0, 0, 1);
    step();
    #2 reset = 1'b0;
    use_bank = 1'b1; target = 4'b0011; target_valid = 1'b1;
    step(); target_valid = 1'b0;
    chk("t5.accept", 32'(target_ready), 32'(0));
    step(); chk_out("t5.e1", 4'b0011, 4'h0, 0, 0, 0);
    step(); step(); chk_out("t5.e3", 4'h0, 4'h0, 1, 0, 1);
    $display("txn 5 reset abort then target=0011 q=%b", q_fb);

    // 6: valid held, target churning; bank starts at 0011
    seq[0] = 4'b0110; seq[1] = 4'b1001; seq[2] = 4'b1111; seq[3] = 4'b0000;
    seq[4] = 4'b1000; seq[5] = 4'b0001; seq[6] = 4'b1110; seq[7] = 4'b0111;
    target = seq[0]; target_valid = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      step();
      if (e < 7) target = seq[e + 1];
      else       target_valid = 1'b0;
      case (e)
        1:       chk_out("t6.e1", 4'b0100, 4'b0001, 0, 0, 0);
        3:       chk_out("t6.e3", 4'h0, 4'h0, 1, 0, 1);
        5:       chk_out("t6.e5", 4'b1000, 4'b0110, 0, 0, 0);
        7:       chk_out("t6.e7", 4'h0, 4'h0, 1, 0, 1);
        default: chk_out($sformatf("t6.e%0d", e), 4'h0, 4'h0, 0, 0, 0);
      endcase
    end
    chk("t6.bank", 32'(q_fb), 32'(4'b1000));
    step(); chk_out("t6.idle", 4'h0, 4'h0, 0, 0, 1);
    $display("txn 6 held valid two ops q=%b", q_fb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Drives a bank of WIDTH external JK flip-flops to a requested target state. It computes per-bit J/K excitation from the target and the flip-flops' fed-back Q, then pulses J/K for one clock. It watches Q until it matches the target, re-drives on timeout, and reports done or error. It is the inverse of the JK flip-flop block: that block turns J/K into Q, this one turns a desired Q into J/K. It sits between a control FSM (valid/ready target port) and a jk_flip_flop bank clocked by the same clk.

## Interface
- WIDTH, 4: number of JK flip-flops driven.
- TIMEOUT, 4: WAIT cycles allowed per drive attempt (≥1).
- RETRIES, 1: extra drive attempts before error (≥0).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock, async active-high reset is fixed.
- target  in  WIDTH  requested Q state.
- target_valid  in  1  target offered.
- target_ready  out  1  high when in IDLE; accepting.
- q_fb  in  WIDTH  Q outputs of the driven JK bank.
- j  out  WIDTH  J inputs to the bank (registered).
- k  out  WIDTH  K inputs to the bank (registered).
- done  out  1  one-cycle pulse: q_fb matched target.
- error  out  1  one-cycle pulse: all attempts timed out.

## Operation
- State machine states are IDLE, DRIVE, WAIT. Internal registers are tgt[WIDTH], cnt (wide enough for TIMEOUT-1) and tries (wide enough for RETRIES).
- Reset asserted:
  - state=IDLE.
  - j=k=0, done=error=0, cnt=tries=0, tgt=0.
  - target_ready=1 immediately; it is combinational from state.
- IDLE:
  - j=k=0.
  - A handshake is target_valid&&target_ready at a rising edge. On a handshake: tgt<=target, tries<=0, state<=DRIVE.
- DRIVE (exactly one cycle):
  - At the edge: j<=~q_fb&tgt and k<=q_fb&~tgt, per bit (minimal excitation).
  - Bits already correct get J=K=0. The block never drives J=K=1.
  - cnt<=0, state<=WAIT.
- WAIT:
  - At each edge: j<=0, k<=0.
  - If q_fb==tgt: done<=1, state<=IDLE.
  - Else if cnt==TIMEOUT-1:
    - If tries<RETRIES: tries<=tries+1, state<=DRIVE.
    - Otherwise: error<=1, state<=IDLE.
  - Else cnt<=cnt+1.
- done and error are registered and cleared at the next edge. They are never both high.
- target_valid and target changes while not in IDLE are ignored. tgt is frozen until the next handshake.
- Reset mid-operation aborts immediately. It drops any J/K pulse in flight; the bank keeps whatever state it reached.

## Timing
- E0 = the edge where the handshake occurs.
  - E1: J/K registered. They are high for exactly one cycle (E1→E2).
  - E2: first match check.
- Target already equal to q_fb: j=k=0 at E1, match at E2, done high in the cycle after E2. This is the minimum latency: 2 edges.
- With a same-clock JK bank, Q updates at E2, is seen at E3, and done is high after E3.
- Each attempt is 1 DRIVE cycle plus up to TIMEOUT WAIT cycles. Worst case to error is (RETRIES+1)·(TIMEOUT+1) edges after E0.
- target_ready rises in the same cycle as the done/error pulse. A held target_valid is accepted at the following edge, so back-to-back operations need no idle gap.

## Test plan
1. Ideal same-clock JK model, q_fb=0000, target=1010 → j=1010, k=0000 for one cycle after E1; done pulse after E3; error never asserted.
2. q_fb=0110, target=0110 → j=k=0000 throughout; done pulse after E2.
3. Mixed case, q_fb=1100, target=0101 → j=0001, k=1000 for one cycle; done after E3; bit 2 (already 1) and bit 1 (already 0) get J=K=0.
4. Stuck bank (q_fb fixed 0000), target=1111, TIMEOUT=4, RETRIES=1:
   - j=1111 pulses after E1 and after E6.
   - error pulse after E10; done stays 0.
   - target_ready returns to 1 at the same point, after E10.
5. Reset asserted mid-WAIT, between clock edges → j, k, done, error go to 0 and target_ready goes to 1 without waiting for a clock edge; a new target is accepted at the first edge after reset deasserts.
6. target_valid held high with target changing every cycle during an operation → only the value at E0 is used; the next value is accepted at the edge after the done edge; done pulses are separated by the expected latency.
